// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared constants and types for the synchronous FIFO read
//                adapter and its 3-entry capture buffer.
//  Contents    : SKID_DEPTH  - capture buffer depth
//                ptr2_t      - 2-bit circular pointer type
//                ptr_inc()   - pointer increment wrapping 2 -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int SKID_DEPTH = 3;

  typedef logic [1:0] ptr2_t;

  // Advance a circular pointer; the buffer has 3 slots, so 2 wraps to 0.
  function automatic ptr2_t ptr_inc(input ptr2_t p);
    return (p == ptr2_t'(SKID_DEPTH - 1)) ? ptr2_t'(0) : ptr2_t'(p + ptr2_t'(1));
  endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/skid_buffer3.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer3
//  Description : 3-entry circular store with occupancy count. Push writes the
//                tail, pop retires the head; simultaneous push and pop keep
//                the count and advance both pointers. The caller guarantees
//                no push when full and no pop when empty.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                i_push/i_push_data - write one word at the tail
//                i_pop           - retire the head word
//                o_head          - word at the head (valid when o_count != 0)
//                o_count         - occupancy 0..3
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer3
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  ptr2_t                 r_head;
  ptr2_t                 r_tail;
  logic [1:0]            r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= ptr_inc(r_tail);
      if (i_pop)  r_head <= ptr_inc(r_head);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: contents are only observed when count != 0.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_push_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule : skid_buffer3
`default_nettype wire

// File: rtl/sync_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_stream_reader
//  Description : Read-side adapter for the synchronous FIFO. Issues FIFO reads,
//                captures the registered read data one cycle later into a
//                3-entry buffer and presents it as a valid/ready stream with
//                packet framing (m_last every PKT_LEN beats).
//  Ports       : clk, rst_n   - clock, synchronous active-low reset
//                en           - allow new FIFO reads
//                fifo_empty   - FIFO empty flag
//                fifo_rdata   - FIFO registered read data
//                fifo_r_en    - FIFO read request
//                m_valid/m_ready/m_data/m_last - downstream stream
//                idle         - buffer empty and no read in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_stream_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  idle
);

  localparam logic [7:0] c_LAST_BEAT = 8'(PKT_LEN - 1);

  logic                  r_pend;
  logic [7:0]            r_beat;
  logic [1:0]            w_count;
  logic [2:0]            w_occupancy;
  logic                  w_issue;
  logic                  w_valid;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head;

  // The in-flight read counts against capacity, so a granted read always
  // has a slot waiting when its data lands. Only registered state feeds
  // this, keeping m_ready off the fifo_r_en path.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_pend};
  assign w_issue     = rst_n & en & ~fifo_empty & (w_occupancy < 3'(SKID_DEPTH));

  assign w_valid = rst_n & (w_count != 2'd0);
  assign w_pop   = w_valid & m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_pend <= 1'b0;
    else        r_pend <= w_issue;
  end

  // Beat position within the current packet; independent of en so a packet
  // may straddle a pause.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == c_LAST_BEAT) ? 8'd0 : r_beat + 8'd1;
    end
  end

  // fifo_rdata is only meaningful the cycle after a granted read.
  skid_buffer3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_pend),
    .i_push_data (fifo_rdata),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign fifo_r_en = w_issue;
  assign m_valid   = w_valid;
  assign m_data    = w_head;
  assign m_last    = w_valid & (r_beat == c_LAST_BEAT);
  assign idle      = ~rst_n | ((w_count == 2'd0) & ~r_pend);

endmodule : sync_fifo_stream_reader
`default_nettype wire

// File: tb/tb_sync_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_stream_reader
//  Description : Self-checking bench for sync_fifo_stream_reader. A FIFO model
//                feeds the adapter; every word written into the model pushes
//                its expected {last, data} onto a scoreboard queue, and a
//                monitor pops and compares on every accepted beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_stream_reader;

  localparam int DW = 8;
  localparam int PL = 4;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          en         = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_r_en;
  logic          m_valid;
  logic          m_ready    = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          idle;

  logic          wr_en    = 1'b0;
  logic [DW-1:0] wr_data  = '0;
  logic          stale_en = 1'b0;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_pops   = 0;
  int            wr_cnt   = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   exp_q[$];

  always #5 clk = ~clk;

  sync_fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (PL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .idle       (idle)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Synchronous FIFO model: requests sampled at the negedge, applied at the
  // posedge, registered read data and empty flag.
  task automatic fifo_model();
    logic          s_ren, s_wen, s_rst, s_stale;
    logic [DW-1:0] s_wd;
    forever begin
      @(negedge clk);
      s_ren = fifo_r_en; s_wen = wr_en; s_wd = wr_data; s_rst = rst_n; s_stale = stale_en;
      @(posedge clk);
      if (!s_rst) begin
        fifo_q.delete();
        exp_q.delete();
        wr_cnt = 0;
        fifo_empty <= 1'b1;
      end else begin
        if (s_ren && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
        else if (s_stale)               fifo_rdata <= 8'hAA;
        if (s_wen) begin
          fifo_q.push_back(s_wd);
          exp_q.push_back({((wr_cnt % PL) == PL - 1), s_wd});
          wr_cnt++;
        end
        fifo_empty <= (fifo_q.size() == 0);
      end
    end
  endtask

  task automatic monitor();
    logic        held = 1'b0;
    logic [DW:0] held_v = '0;
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (fifo_r_en) check("no_read_when_empty", 32'(fifo_empty), 32'd0);
        if (held) check("stable_while_stalled", {m_valid, m_last, m_data}, {1'b1, held_v});
        if (m_valid && m_ready) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got %0h expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(m_data), 32'(e[DW-1:0]));
            check("beat_last", 32'(m_last), 32'(e[DW]));
          end
        end
        held   = m_valid && !m_ready;
        held_v = {m_last, m_data};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    logic done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (idle && !fifo_r_en && exp_q.size() == 0 && fifo_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
    tick();
  endtask

  task automatic wait_data(input string name, input logic [DW-1:0] d, input logic exp_last);
    logic found = 1'b0;
    logic lst   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid && m_data == d) begin
        found = 1'b1;
        lst   = m_last;
        break;
      end
    end
    check(name, {30'd0, found, lst}, {30'd0, 1'b1, exp_last});
    tick();
  endtask

  initial begin
    int rc;
    int base;
    int pushed;
    int cyc;
    logic any_valid;

    fork
      fifo_model();
      monitor();
    join_none

    // ---------------- reset state
    tick(); tick();
    @(negedge clk);
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_r_en", 32'(fifo_r_en), 32'd0);
    check("reset_idle", 32'(idle), 32'd1);
    check("reset_m_last", 32'(m_last), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- basic stream
    m_ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    en = 1'b1;
    @(negedge clk);
    check("basic_r_en_t", 32'(fifo_r_en), 32'd1);
    @(negedge clk);
    check("basic_valid_t1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("basic_valid_t2", {m_valid, m_last, m_data}, {1'b1, 1'b0, 8'h11});
    wait_data("basic_last_44", 8'h44, 1'b1);
    wait_idle("basic_idle", 20);

    // ---------------- backpressure
    m_ready = 1'b0;
    rc = 0;
    for (int i = 0; i < 12; i++) begin
      wr_en   = (i < 8);
      wr_data = 8'h80 + 8'(i);
      @(negedge clk);
      if (fifo_r_en) rc++;
      tick();
    end
    wr_en = 1'b0;
    check("bp_read_count", 32'(rc), 32'd3);
    @(negedge clk);
    check("bp_hold", {fifo_r_en, m_valid, m_last, m_data}, {1'b0, 1'b1, 1'b0, 8'h80});
    tick();
    base = n_pops;
    m_ready = 1'b1;
    wait_idle("bp_drain_idle", 40);
    check("bp_pop_count", 32'(n_pops - base), 32'd8);

    // ---------------- stale read data ignored
    base = n_pops;
    stale_en = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      any_valid = any_valid | m_valid;
      tick();
    end
    stale_en = 1'b0;
    check("stale_no_valid", {any_valid, idle}, {1'b0, 1'b1});
    check("stale_no_pop", 32'(n_pops - base), 32'd0);

    // ---------------- en gating (beat count now at 0)
    en = 1'b0;
    for (int i = 1; i <= 6; i++) push_word(8'(i));
    en = 1'b1;
    @(negedge clk);
    check("gate_first_issue", 32'(fifo_r_en), 32'd1);
    tick();
    en = 1'b0;
    base = n_pops;
    rc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_r_en) rc++;
      tick();
    end
    check("gate_no_issue", 32'(rc), 32'd0);
    check("gate_inflight_delivered", 32'(n_pops - base), 32'd1);
    en = 1'b1;
    wait_data("gate_last_on_4th", 8'h04, 1'b1);
    wait_idle("gate_idle", 30);

    // ---------------- reset mid-operation
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h41 + 8'(i));
    en = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    check("pre_rst_state", {fifo_r_en, m_valid, idle}, {1'b0, 1'b1, 1'b0});
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_outputs", {m_valid, fifo_r_en, idle, m_last}, {1'b0, 1'b0, 1'b1, 1'b0});
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    push_word(8'h51); push_word(8'h52); push_word(8'h53); push_word(8'h54);
    wait_data("post_rst_last", 8'h54, 1'b1);
    wait_idle("post_rst_idle", 20);

    // ---------------- random throughput
    base = n_pops;
    pushed = 0;
    cyc = 0;
    en = 1'b1;
    while ((pushed < 1000 || !(idle && exp_q.size() == 0 && fifo_q.size() == 0)) && cyc < 20000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        wr_en   = 1'b1;
        wr_data = DW'($urandom);
        pushed++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    check("rand_pop_count", 32'(n_pops - base), 32'd1000);
    check("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sync_fifo_stream_reader
`default_nettype wire

// File: doc/sync_fifo_stream_reader.md
# sync_fifo_stream_reader

Read-side adapter for the team's synchronous FIFO: it drives the FIFO read enable, captures the registered read data one cycle after each pop, and presents the words as a valid/ready stream with packet framing. It sits between the FIFO's read port (r_en / data_out / empty) and any downstream consumer that can stall. A 3-entry capture buffer sustains one word per cycle with no combinational path from `m_ready` to `fifo_r_en`.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the FIFO's data width.
- `PKT_LEN`, default 4: number of beats per packet; `m_last` marks the final beat. Legal range is 1..255.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `en` input, 1 bit: read enable. While 0, no new FIFO reads are issued; buffered and in-flight words still drain.
- `fifo_empty` input, 1 bit: the FIFO's empty flag.
- `fifo_rdata` input, DATA_WIDTH bits: the FIFO's registered read data. It is valid in the cycle after an accepted read and holds its value otherwise.
- `fifo_r_en` output, 1 bit: FIFO read request.
- `m_valid` output, 1 bit: downstream word available.
- `m_ready` input, 1 bit: downstream accepts the word.
- `m_data` output, DATA_WIDTH bits: downstream word.
- `m_last` output, 1 bit: the current beat is the last of its packet.
- `idle` output, 1 bit: buffer empty and no read in flight.

## Operation
- **Read issue (combinational, registered state only):** `fifo_r_en = rst_n & en & !fifo_empty & (count + pend < 3)`.
  - `count` is the buffer occupancy (0..3).
  - `pend` is a 1-bit flag meaning a read was issued in the previous cycle.
  - Every read the adapter asserts is therefore accepted by the FIFO.
- **Pending flag:** `pend <= fifo_r_en` each cycle.
- **Capture:** when `pend` = 1, write `fifo_rdata` into the buffer tail. `fifo_rdata` is ignored when `pend` = 0, even if it changes or holds a stale value.
- **Buffer:** a 3-entry circular buffer with 2-bit head and tail pointers that wrap 2→0.
  - `m_valid = (count != 0)`; `m_data` is the head entry.
  - A pop occurs when `m_valid & m_ready`.
  - Simultaneous capture and pop: `count` is unchanged and both pointers advance.
  - Overflow cannot occur, because the issue rule counts the in-flight read.
- **Framing:** the beat counter `beat` runs 0..PKT_LEN-1 and advances on each pop, wrapping to 0 after PKT_LEN-1.
  - `m_last = m_valid & (beat == PKT_LEN-1)`.
  - With PKT_LEN = 1, every beat is last.
  - `en` does not reset `beat`; a packet may straddle an `en` low period.
- **idle:** `idle = (count == 0) & !pend`.
- **AXI-style stability:** once `m_valid` is high, `m_data` and `m_last` stay stable until the pop.
- **Reset (rst_n low at a clock edge):**
  - `count`, `pend`, pointers and `beat` all clear to 0.
  - `fifo_r_en` = 0 and `m_valid` = 0 for as long as `rst_n` is low.
  - `m_data` is don't-care; `m_last` = 0 and `idle` = 1.
  - Buffered words are discarded. The FIFO is reset in the same cycle by the shared `rst_n`.

## Timing
- Read-to-output latency: `fifo_r_en` is high in cycle t, `fifo_rdata` is valid in t+1, the word is captured at the end of t+1, and `m_valid` is high in t+2.
- Throughput: 1 word per cycle sustained while `m_ready` = 1 and the FIFO is non-empty. In steady state `count` = 1 and `pend` = 1, so issue is allowed.
- Stall: with `m_ready` = 0, at most 3 reads are outstanding (buffer plus pending). `fifo_r_en` drops once `count + pend` = 3.
- Restart after stall: the first pop frees a slot. `fifo_r_en` is reasserted the following cycle, with no bubble at the output while the buffer stays above 1.
- `fifo_empty` falling (the FIFO receives data): `fifo_r_en` is asserted in the same cycle.
- `en` falling: takes effect in the same cycle for issue. A pending read is still captured.

## Structure
- Shared package `sync_fifo_pkg` holds:
  - the `SKID_DEPTH` = 3 constant;
  - the `ptr2_t` typedef for 2-bit pointers.
- Natural sub-module: `skid_buffer3`, the 3-entry circular store with count and pointers, push/pop and head output.
- The top level holds the issue logic, `pend` and the beat counter.

## Test plan
- **Basic stream:** preload a FIFO model with 0x11, 0x22, 0x33, 0x44, then set `en` = 1 with `m_ready` held at 1.
  - `m_data` delivers 11, 22, 33, 44 on consecutive cycles, starting 2 cycles after the first `fifo_r_en`.
  - `m_last` is high only on 0x44 (PKT_LEN = 4).
  - `idle` returns to 1 afterwards.
- **Backpressure:** 8 words queued with `m_ready` = 0.
  - Exactly 3 reads are issued, then `fifo_r_en` stays 0 and `m_data` holds word 0.
  - After releasing `m_ready`, all 8 words arrive in order with none lost or duplicated.
- **Stale data ignored:** FIFO empty while `fifo_rdata` toggles to 0xAA.
  - `m_valid` stays 0 and nothing is captured.
- **en gating:** drop `en` in the cycle after a read is issued.
  - That word is still delivered and no further `fifo_r_en` follows.
  - Reasserting `en` resumes reading, and the `beat` count continues (e.g. `m_last` appears on the 4th total beat).
- **Reset mid-operation:** assert `rst_n` = 0 with 2 words buffered and `pend` = 1.
  - Next cycle: `m_valid` = 0, `fifo_r_en` = 0, `idle` = 1.
  - After release, the first new packet begins at beat 0.
- **Random throughput:** random `m_ready` (50%) and random FIFO fills over 1000 words.
  - A scoreboard confirms in-order delivery, `m_last` exactly every PKT_LEN beats, and no read while `fifo_empty` = 1.
